simon_key_schedule: RTL and testbench

SIMON_KEY_SCHEDULE -- requirements
Module: simon_key_schedule

---
 rtl/simon_key_schedule.sv | 157 +++++++++++++++
 tb/tb_simon_key_schedule.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/simon_key_schedule.sv
// SIMON64/128 key expansion: accepts a 4-word master key and streams ROUNDS round keys,
// one per cycle, under a valid/ready handshake.
module simon_key_schedule #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned ROUNDS = 44,
    parameter logic [63:0] Z      = 64'h3C2CE51207A635DB
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 key_valid,
    input  logic [4*WIDTH-1:0]   key_in,
    output logic                 key_ready,
    output logic                 rk_valid,
    input  logic                 rk_ready,
    output logic [WIDTH-1:0]     rk,
    output logic [5:0]           rk_idx,
    output logic                 rk_last
);

    localparam int unsigned      IDX_W    = 6;
    localparam logic [0:0]       S_IDLE   = 1'b0;
    localparam logic [0:0]       S_RUN    = 1'b1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROUNDS - 1);

    logic [0:0]       r_state;
    logic [WIDTH-1:0] r_w0;
    logic [WIDTH-1:0] r_w1;
    logic [WIDTH-1:0] r_w2;
    logic [WIDTH-1:0] r_w3;
    logic [IDX_W-1:0] r_i;
    logic             r_key_ready;
    logic             r_rk_valid;
    logic [WIDTH-1:0] r_rk;
    logic [IDX_W-1:0] r_rk_idx;
    logic             r_rk_last;

    logic [0:0]       w_state_nxt;
    logic [WIDTH-1:0] w_w0_nxt;
    logic [WIDTH-1:0] w_w1_nxt;
    logic [WIDTH-1:0] w_w2_nxt;
    logic [WIDTH-1:0] w_w3_nxt;
    logic [IDX_W-1:0] w_i_nxt;
    logic             w_key_ready_nxt;
    logic             w_rk_valid_nxt;
    logic [WIDTH-1:0] w_rk_nxt;
    logic [IDX_W-1:0] w_rk_idx_nxt;
    logic             w_rk_last_nxt;

    logic [WIDTH-1:0] w_t;
    logic [WIDTH-1:0] w_new;
    logic             w_key_hs;
    logic             w_rk_hs;

    // Next schedule word: ~k[i] ^ t ^ ror1(t) ^ z[i] ^ 3, with t = ror3(k[i+3]) ^ k[i+1]
    assign w_t      = {r_w3[2:0], r_w3[WIDTH-1:3]} ^ r_w1;
    assign w_new    = ~r_w0 ^ w_t ^ {w_t[0], w_t[WIDTH-1:1]}
                      ^ {{(WIDTH-1){1'b0}}, Z[r_i]} ^ WIDTH'(3);
    assign w_key_hs = key_valid & r_key_ready;
    assign w_rk_hs  = r_rk_valid & rk_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_w0    <= '0;
            r_w1    <= '0;
            r_w2    <= '0;
            r_w3    <= '0;
            r_i     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_w0    <= w_w0_nxt;
            r_w1    <= w_w1_nxt;
            r_w2    <= w_w2_nxt;
            r_w3    <= w_w3_nxt;
            r_i     <= w_i_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_w0_nxt    = r_w0;
        w_w1_nxt    = r_w1;
        w_w2_nxt    = r_w2;
        w_w3_nxt    = r_w3;
        w_i_nxt     = r_i;

        case (r_state)
            S_IDLE: begin
                if (w_key_hs) begin
                    w_w0_nxt    = key_in[WIDTH-1:0];
                    w_w1_nxt    = key_in[2*WIDTH-1:WIDTH];
                    w_w2_nxt    = key_in[3*WIDTH-1:2*WIDTH];
                    w_w3_nxt    = key_in[4*WIDTH-1:3*WIDTH];
                    w_i_nxt     = '0;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (w_rk_hs) begin
                    w_w0_nxt = r_w1;
                    w_w1_nxt = r_w2;
                    w_w2_nxt = r_w3;
                    w_w3_nxt = w_new;
                    // Counter parks at 0 after the last key so it never passes ROUNDS-1
                    if (r_i == LAST_IDX) begin
                        w_i_nxt     = '0;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_i_nxt = r_i + IDX_W'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Outputs are registered copies of the next-state view, so rk tracks W0 with no extra latency
    always_comb begin
        w_key_ready_nxt = 1'b1;
        w_rk_valid_nxt  = 1'b0;
        w_rk_nxt        = '0;
        w_rk_idx_nxt    = '0;
        w_rk_last_nxt   = 1'b0;
        if (w_state_nxt == S_RUN) begin
            w_key_ready_nxt = 1'b0;
            w_rk_valid_nxt  = 1'b1;
            w_rk_nxt        = w_w0_nxt;
            w_rk_idx_nxt    = w_i_nxt;
            w_rk_last_nxt   = (w_i_nxt == LAST_IDX);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_key_ready <= 1'b1;
            r_rk_valid  <= 1'b0;
            r_rk        <= '0;
            r_rk_idx    <= '0;
            r_rk_last   <= 1'b0;
        end else begin
            r_key_ready <= w_key_ready_nxt;
            r_rk_valid  <= w_rk_valid_nxt;
            r_rk        <= w_rk_nxt;
            r_rk_idx    <= w_rk_idx_nxt;
            r_rk_last   <= w_rk_last_nxt;
        end
    end

    assign key_ready = r_key_ready;
    assign rk_valid  = r_rk_valid;
    assign rk        = r_rk;
    assign rk_idx    = r_rk_idx;
    assign rk_last   = r_rk_last;

endmodule

// File: tb/tb_simon_key_schedule.sv
// Directed bench for simon_key_schedule: reference vector, end-to-end cipher,
// backpressure, ignored key, and asynchronous reset cases.
module tb_simon_key_schedule;

    localparam int ROUNDS = 44;
    localparam logic [127:0] KEY   = 128'h1b1a1918_13121110_0b0a0908_03020100;
    localparam logic [127:0] ALT   = 128'hdeadbeef_cafef00d_01234567_89abcdef;
    localparam logic [63:0]  Z3    = 64'h3C2CE51207A635DB;
    localparam logic [63:0]  PT    = 64'h656b696c_20646e75;
    localparam logic [63:0]  CT    = 64'h44c8fc20_b9dfa07a;

    logic          clk = 1'b0;
    logic          rst;
    logic          key_valid;
    logic [127:0]  key_in;
    logic          key_ready;
    logic          rk_valid;
    logic          rk_ready;
    logic [31:0]   rk;
    logic [5:0]    rk_idx;
    logic          rk_last;

    int            errors = 0;
    int            checks = 0;
    logic [31:0]   exp_rk [0:ROUNDS-1];
    logic [31:0]   cap    [0:ROUNDS-1];
    logic [31:0]   vec5   [0:4];

    simon_key_schedule dut (
        .clk       (clk),
        .rst       (rst),
        .key_valid (key_valid),
        .key_in    (key_in),
        .key_ready (key_ready),
        .rk_valid  (rk_valid),
        .rk_ready  (rk_ready),
        .rk        (rk),
        .rk_idx    (rk_idx),
        .rk_last   (rk_last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] ror32(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] rol32(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    // Reference expansion of the master key into exp_rk
    function automatic void gen_exp(input logic [127:0] key);
        logic [31:0] tmp;
        for (int j = 0; j < 4; j++) exp_rk[j] = key[32*j +: 32];
        for (int j = 0; j < ROUNDS - 4; j++) begin
            tmp = ror32(exp_rk[j+3], 3) ^ exp_rk[j+1];
            tmp = tmp ^ ror32(tmp, 1);
            exp_rk[j+4] = ~exp_rk[j] ^ tmp ^ 32'((Z3 >> j) & 64'd1) ^ 32'd3;
        end
    endfunction

    function automatic logic [63:0] encrypt(input logic [63:0] pt);
        logic [31:0] x, y, tmp;
        x = pt[63:32];
        y = pt[31:0];
        for (int r = 0; r < ROUNDS; r++) begin
            tmp = x;
            x = y ^ ((rol32(x, 1) & rol32(x, 8)) ^ rol32(x, 2)) ^ cap[r];
            y = tmp;
        end
        return {x, y};
    endfunction

    task automatic check_idle(input string tag);
        chk({tag, ".key_ready"}, 64'(key_ready), 64'(1));
        chk({tag, ".rk_valid"},  64'(rk_valid),  64'(0));
        chk({tag, ".rk"},        64'(rk),        64'(0));
        chk({tag, ".rk_idx"},    64'(rk_idx),    64'(0));
        chk({tag, ".rk_last"},   64'(rk_last),   64'(0));
    endtask

    task automatic check_key(input int idx);
        chk($sformatf("rk_valid[%0d]", idx),  64'(rk_valid),  64'(1));
        chk($sformatf("rk_idx[%0d]", idx),    64'(rk_idx),    64'(idx));
        chk($sformatf("rk[%0d]", idx),        64'(rk),        64'(exp_rk[idx]));
        chk($sformatf("rk_last[%0d]", idx),   64'(rk_last),   64'(idx == ROUNDS - 1));
        chk($sformatf("key_ready[%0d]", idx), 64'(key_ready), 64'(0));
        if (idx < 5) chk($sformatf("rk_vec[%0d]", idx), 64'(rk), 64'(vec5[idx]));
    endtask

    task automatic start_key(input logic [127:0] k);
        key_valid = 1'b1;
        key_in    = k;
        step();
        key_valid = 1'b0;
    endtask

    // mode 0 streaming, 1 five-cycle stall at idx 2, 2 toggling ready, 3 foreign key pulse at idx 10
    task automatic run_seq(input int mode, input int stop_idx, input logic [127:0] alt_key);
        int   idx;
        int   cyc;
        int   stall;
        bit   pulsed;
        logic rdy;
        idx = 0; cyc = 0; stall = 0; pulsed = 1'b0;
        while (idx < ROUNDS) begin
            check_key(idx);
            if (idx == stop_idx) return;
            key_valid = 1'b0;
            rdy = 1'b1;
            if (mode == 1 && idx == 2 && stall < 5) begin
                rdy = 1'b0;
                stall++;
            end
            if (mode == 2) rdy = (cyc % 2 == 1);
            if (mode == 3 && idx == 10 && !pulsed) begin
                key_valid = 1'b1;
                key_in    = alt_key;
                pulsed    = 1'b1;
            end
            if (rdy) cap[idx] = rk;
            rk_ready = rdy;
            step();
            cyc++;
            if (rdy) idx++;
        end
        key_valid = 1'b0;
        check_idle($sformatf("done_m%0d", mode));
    endtask

    initial begin
        vec5[0] = 32'h03020100;
        vec5[1] = 32'h0b0a0908;
        vec5[2] = 32'h13121110;
        vec5[3] = 32'h1b1a1918;
        vec5[4] = 32'h70a011c3;
        rst       = 1'b0;
        key_valid = 1'b0;
        key_in    = '0;
        rk_ready  = 1'b0;

        #2 rst = 1'b1;
        #2 check_idle("reset");
        step();
        rst = 1'b0;
        step();
        check_idle("post_reset");

        gen_exp(KEY);
        rk_ready = 1'b1;

        start_key(KEY);
        run_seq(0, -1, '0);
        chk("ct_stream", encrypt(PT), CT);

        start_key(KEY);
        run_seq(1, -1, '0);

        start_key(KEY);
        run_seq(2, -1, '0);
        chk("ct_toggle", encrypt(PT), CT);

        start_key(KEY);
        run_seq(3, -1, ALT);

        rk_ready = 1'b1;
        start_key(KEY);
        run_seq(0, 20, '0);
        #3 rst = 1'b1;
        #1 check_idle("async_rst");
        step();
        rst = 1'b0;
        step();
        check_idle("after_rst");
        start_key(KEY);
        run_seq(0, -1, '0);
        chk("ct_restart", encrypt(PT), CT);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
